// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: default widths, op codes and FSM states.
// Op codes 13-15 are undefined; 10-12 are legal only when EXEC_MULDIV_EN is defined.
package exec_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int OP_W_DEF   = 4;

    localparam logic [OP_W_DEF-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W_DEF-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W_DEF-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W_DEF-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W_DEF-1:0] OP_NOR   = 4'd4;
    localparam logic [OP_W_DEF-1:0] OP_SLT   = 4'd5;
    localparam logic [OP_W_DEF-1:0] OP_SLTU  = 4'd6;
    localparam logic [OP_W_DEF-1:0] OP_SLL   = 4'd7;
    localparam logic [OP_W_DEF-1:0] OP_SRL   = 4'd8;
    localparam logic [OP_W_DEF-1:0] OP_SRA   = 4'd9;
    localparam logic [OP_W_DEF-1:0] OP_MULLO = 4'd10;
    localparam logic [OP_W_DEF-1:0] OP_DIVU  = 4'd11;
    localparam logic [OP_W_DEF-1:0] OP_REMU  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/exec_muldiv_seq.sv
// Iterative unsigned engine: shift-add multiply (low half) or restoring divide, one bit per cycle.
// Latency DATA_W cycles from start; done/result are combinational on the final iteration cycle.
// No backpressure: start is only issued while idle and done is consumed the same cycle.
module exec_muldiv_seq
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic              active_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   op_q;
    // acc: product accumulator or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
    logic [DATA_W-1:0] acc_q, x_q, y_q;
    logic [DATA_W-1:0] acc_nx, x_nx, y_nx;
    logic [DATA_W:0]   rem_sh, diff;
    logic              is_div;

    assign is_div = (op_q != OP_MULLO);

    always_comb begin
        acc_nx = acc_q;
        x_nx   = x_q;
        y_nx   = y_q;
        rem_sh = '0;
        diff   = '0;
        if (is_div) begin
            rem_sh = {acc_q, x_q[DATA_W-1]};
            diff   = rem_sh - {1'b0, y_q};
            acc_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
            x_nx   = {x_q[DATA_W-2:0], ~diff[DATA_W]};
        end else begin
            acc_nx = acc_q + (y_q[0] ? x_q : '0);
            x_nx   = x_q << 1;
            y_nx   = y_q >> 1;
        end
    end

    assign done   = active_q && (cnt_q == LAST);
    assign result = (op_q == OP_REMU) ? acc_nx : (is_div ? x_nx : acc_nx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            op_q     <= op;
            acc_q    <= '0;
            x_q      <= a;
            y_q      <= b;
        end else if (active_q) begin
            acc_q <= acc_nx;
            x_q   <= x_nx;
            y_q   <= y_nx;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_alu_muldiv.sv
// Execute stage: single-cycle ALU (latency 1) plus iterative MULLO/DIVU/REMU (latency DATA_W) when EXEC_MULDIV_EN is defined.
// in_ready drops while an iterative op is in flight; outputs have no backpressure (out_valid is a 1-cycle pulse).
module exec_alu_muldiv
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [4:0]        shamt,
    input  logic [REG_AW-1:0] dest_in,
    input  logic              wr_en_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic [REG_AW-1:0] dest_out,
    output logic              wr_en_out,
    output logic              illegal_op
);

    logic              accept;
    logic [DATA_W-1:0] alu_res;
    logic              alu_legal;
    logic              alu_multi;
    logic              seq_done;
    logic [DATA_W-1:0] seq_result;
    logic [REG_AW-1:0] dest_q;
    logic              wr_q;

    assign accept = in_valid & in_ready;

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        alu_multi = 1'b0;
        case (op)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_NOR:  alu_res = ~(operand_a | operand_b);
            OP_SLT:  alu_res = DATA_W'($signed(operand_a) < $signed(operand_b));
            OP_SLTU: alu_res = DATA_W'(operand_a < operand_b);
            OP_SLL:  alu_res = operand_a << shamt;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> shamt);
`ifdef EXEC_MULDIV_EN
            OP_MULLO: alu_multi = 1'b1;
            // Divide by zero resolves immediately instead of iterating
            OP_DIVU: begin
                if (operand_b == '0) alu_res = '1;
                else                 alu_multi = 1'b1;
            end
            OP_REMU: begin
                if (operand_b == '0) alu_res = operand_a;
                else                 alu_multi = 1'b1;
            end
`endif
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    state_t state_q, state_d;
    logic   seq_start;

    assign seq_start = accept & alu_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (seq_start) state_d = (op == OP_MULLO) ? MUL : DIV;
            MUL,
            DIV:     if (seq_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Write-back target is held here until the iterative result retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_q <= '0;
            wr_q   <= 1'b0;
        end else if (seq_start) begin
            dest_q <= dest_in;
            wr_q   <= wr_en_in;
        end
    end

    exec_muldiv_seq #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (seq_start),
        .op     (op),
        .a      (operand_a),
        .b      (operand_b),
        .done   (seq_done),
        .result (seq_result)
    );
`else
    assign in_ready   = 1'b1;
    assign seq_done   = 1'b0;
    assign seq_result = '0;
    assign dest_q     = '0;
    assign wr_q       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            dest_out   <= '0;
            wr_en_out  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            wr_en_out  <= 1'b0;
            illegal_op <= 1'b0;
            if (accept && !alu_multi) begin
                out_valid  <= 1'b1;
                result     <= alu_res;
                zero       <= (alu_res == '0);
                dest_out   <= dest_in;
                wr_en_out  <= wr_en_in & alu_legal;
                illegal_op <= ~alu_legal;
            end else if (seq_done) begin
                out_valid  <= 1'b1;
                result     <= seq_result;
                zero       <= (seq_result == '0);
                dest_out   <= dest_q;
                wr_en_out  <= wr_q;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu_muldiv.sv
// Directed bench for exec_alu_muldiv: back-to-back single-cycle vectors plus iterative and reset corner cases.
module tb_exec_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  dest_in = '0;
    logic        wr_en_in = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  dest_out;
    logic        wr_en_out;
    logic        illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    exec_alu_muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .shamt      (shamt),
        .dest_in    (dest_in),
        .wr_en_in   (wr_en_in),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero),
        .dest_out   (dest_out),
        .wr_en_out  (wr_en_out),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        wro;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] sh,
                                logic [4:0] d, logic wr, logic [31:0] res, logic ill);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.sh = sh; v.dest = d; v.wr = wr;
        v.res = res; v.z = (res == 32'd0); v.ill = ill; v.wro = wr & ~ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        op        = v.op;
        operand_a = v.a;
        operand_b = v.b;
        shamt     = v.sh;
        dest_in   = v.dest;
        wr_en_in  = v.wr;
    endtask

`ifdef EXEC_MULDIV_EN
    // Launch an iterative op, pulse in_valid while busy, and check latency and result
    task automatic run_multi(input string name, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int cyc;
        bit got;
        drive(mk(o, a, b, 5'd0, d, 1'b1, 32'd0, 1'b0));
        @(posedge clk); #1;
        got = 1'b0;
        cyc = 0;
        chk({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 40 && !got; k++) begin
            if (k <= 30) drive(mk(4'd0, 32'd1, 32'd1, 5'd0, 5'd31, 1'b1, 32'd2, 1'b0));
            else         in_valid = 1'b0;
            in_valid = (k <= 30) && k[0];
            @(posedge clk); #1;
            if (out_valid) begin
                got = 1'b1;
                cyc = k;
            end
        end
        in_valid = 1'b0;
        chk({name, " done seen"}, {31'd0, got}, 32'd1);
        chk({name, " latency"}, cyc, 32'd32);
        chk({name, " result"}, result, exp);
        chk({name, " dest_out"}, {27'd0, dest_out}, {27'd0, d});
        chk({name, " wr_en_out"}, {31'd0, wr_en_out}, 32'd1);
        @(posedge clk); #1;
        chk({name, " no extra pulse"}, {31'd0, out_valid}, 32'd0);
    endtask
`endif

    initial begin
        vecs.push_back(mk(4'd0,  32'd5,        32'd7,        5'd0,  5'd3,  1'b1, 32'd12,       1'b0));
        vecs.push_back(mk(4'd1,  32'h1234,     32'h1234,     5'd0,  5'd4,  1'b1, 32'd0,        1'b0));
        vecs.push_back(mk(4'd3,  32'hF0,       32'h0F,       5'd0,  5'd5,  1'b1, 32'hFF,       1'b0));
        vecs.push_back(mk(4'd2,  32'hFF00FF00, 32'h0FF00FF0, 5'd0,  5'd6,  1'b1, 32'h0F000F00, 1'b0));
        vecs.push_back(mk(4'd4,  32'd0,        32'd0,        5'd0,  5'd7,  1'b1, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(4'd4,  32'hFFFF0000, 32'h0000FFFF, 5'd0,  5'd8,  1'b1, 32'd0,        1'b0));
        vecs.push_back(mk(4'd5,  32'hFFFFFFFF, 32'd1,        5'd0,  5'd9,  1'b1, 32'd1,        1'b0));
        vecs.push_back(mk(4'd6,  32'hFFFFFFFF, 32'd1,        5'd0,  5'd10, 1'b1, 32'd0,        1'b0));
        vecs.push_back(mk(4'd6,  32'd1,        32'hFFFFFFFF, 5'd0,  5'd11, 1'b1, 32'd1,        1'b0));
        vecs.push_back(mk(4'd7,  32'd1,        32'd0,        5'd31, 5'd12, 1'b1, 32'h80000000, 1'b0));
        vecs.push_back(mk(4'd8,  32'h80000000, 32'd0,        5'd4,  5'd13, 1'b1, 32'h08000000, 1'b0));
        vecs.push_back(mk(4'd9,  32'h80000000, 32'd0,        5'd4,  5'd14, 1'b1, 32'hF8000000, 1'b0));
        vecs.push_back(mk(4'd9,  32'h7FFFFFFF, 32'd0,        5'd31, 5'd15, 1'b1, 32'd0,        1'b0));
        vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'd1,        5'd0,  5'd16, 1'b0, 32'd0,        1'b0));
        vecs.push_back(mk(4'd1,  32'd0,        32'd1,        5'd0,  5'd17, 1'b1, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(4'd15, 32'd3,        32'd4,        5'd0,  5'd18, 1'b1, 32'd0,        1'b1));
`ifdef EXEC_MULDIV_EN
        vecs.push_back(mk(4'd11, 32'd9,        32'd0,        5'd0,  5'd19, 1'b1, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(4'd12, 32'd9,        32'd0,        5'd0,  5'd20, 1'b1, 32'd9,        1'b0));
`else
        vecs.push_back(mk(4'd10, 32'd7,        32'd6,        5'd0,  5'd19, 1'b1, 32'd0,        1'b1));
        vecs.push_back(mk(4'd11, 32'd9,        32'd0,        5'd0,  5'd20, 1'b1, 32'd0,        1'b1));
        vecs.push_back(mk(4'd12, 32'd9,        32'd0,        5'd0,  5'd21, 1'b1, 32'd0,        1'b1));
`endif

        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'd0, zero, wr_en_out, illegal_op, |dest_out}, 32'd0);
        #10 rst_n = 1'b1;

        // Vectors are issued back-to-back: each is driven in the cycle its predecessor's result appears
        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d result", i), result, vecs[i].res);
            chk($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
            chk($sformatf("v%0d illegal_op", i), {31'd0, illegal_op}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d wr_en_out", i), {31'd0, wr_en_out}, {31'd0, vecs[i].wro});
            chk($sformatf("v%0d dest_out", i), {27'd0, dest_out}, {27'd0, vecs[i].dest});
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            if (i + 1 < vecs.size()) drive(vecs[i+1]);
            else                     in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("idle out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle wr_en_out", {31'd0, wr_en_out}, 32'd0);
        chk("idle dest hold", {27'd0, dest_out}, {27'd0, vecs[vecs.size()-1].dest});

`ifdef EXEC_MULDIV_EN
        run_multi("mullo 7*6", 4'd10, 32'd7, 32'd6, 5'd21, 32'd42);
        run_multi("mullo 2^16*2^16", 4'd10, 32'h00010000, 32'h00010000, 5'd22, 32'd0);
        run_multi("divu 100/7", 4'd11, 32'd100, 32'd7, 5'd23, 32'd14);
        run_multi("remu 100%7", 4'd12, 32'd100, 32'd7, 5'd24, 32'd2);
        run_multi("divu max/1", 4'd11, 32'hFFFFFFFF, 32'd1, 5'd25, 32'hFFFFFFFF);

        // Reset during an in-flight multiply must discard it
        begin
            int pulses;
            drive(mk(4'd10, 32'd7, 32'd6, 5'd0, 5'd26, 1'b1, 32'd42, 1'b0));
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
            #2 rst_n = 1'b1;
            pulses = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid) pulses++;
            end
            chk("rst mid no result", pulses, 32'd0);
        end
`endif

        drive(mk(4'd0, 32'd2, 32'd3, 5'd0, 5'd27, 1'b1, 32'd5, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("final add valid", {31'd0, out_valid}, 32'd1);
        chk("final add result", result, 32'd5);
        chk("final add dest", {27'd0, dest_out}, 32'd27);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_alu_muldiv.md
Name: exec_alu_muldiv

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two read-port operands and the decoded op.
- Produces a registered result with its destination register address and write enable, which feed the register-file write port.
- Single-cycle ALU ops, plus iterative unsigned multiply/divide under a ready/valid input handshake.

Parameters:
DATA_W, 32, operand/result width.
REG_AW, 5, register address width.
OP_W, 4, operation code width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands/op valid this cycle.
in_ready  out  1  block can accept; accept = in_valid & in_ready at rising edge.
op  in  OP_W  operation code (see package).
operand_a  in  DATA_W  register-file read port 1 data.
operand_b  in  DATA_W  register-file read port 2 data.
shamt  in  5  shift amount.
dest_in  in  REG_AW  destination register address.
wr_en_in  in  1  instruction writes back.
out_valid  out  1  one-cycle pulse, result valid.
result  out  DATA_W  registered result.
zero  out  1  result == 0, registered with result.
dest_out  out  REG_AW  dest_in captured at accept.
wr_en_out  out  1  write-back enable; asserted only together with out_valid.
illegal_op  out  1  one-cycle pulse with out_valid for an undefined op.

Behaviour:
- Reset values:
  - in_ready=1.
  - out_valid, result, zero, dest_out, wr_en_out, illegal_op all 0.
  - FSM=IDLE, iteration counter=0.
- No output backpressure; out_valid is a single-cycle pulse.
- FSM states:
  - IDLE:
    - in_ready=1.
    - Accepting a single-cycle op: result registered at the same edge, out_valid high for exactly the next cycle (latency 1); remains in IDLE, so back-to-back accepts give consecutive out_valid pulses.
    - Accepting MULLO/DIVU/REMU: operands captured, counter cleared, moves to MUL or DIV; no out_valid.
  - MUL:
    - in_ready=0.
    - Shift-add, one bit per cycle, DATA_W iterations.
    - On the edge completing the last iteration: low DATA_W product bits go to result, out_valid=1, return to IDLE.
    - Latency DATA_W cycles from accept.
  - DIV:
    - in_ready=0.
    - Restoring unsigned division, DATA_W iterations, same timing as MUL.
    - Result is the quotient (DIVU) or remainder (REMU).
- in_ready drops in the cycle after a multi-cycle accept. in_valid while busy is ignored (not captured); upstream holds it.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W, no overflow flag.
  - SLT is signed, SLTU unsigned; result is 1 or 0.
  - SLL/SRL/SRA use shamt; SRA sign-fills.
  - NOR = ~(a|b).
- Divide by zero (operand_b==0 at accept): no iteration; result DIVU=all ones, REMU=operand_a; latency 1; stays IDLE.
- Undefined op: result 0, wr_en_out 0, illegal_op=1, out_valid=1, latency 1.
- dest_out and wr_en_out update only with out_valid; they hold value otherwise, but wr_en_out is 0 whenever out_valid is 0.
- Reset asserted mid-operation: immediate return to reset values; the in-flight result is discarded and never emitted.

Optional Feature:
- Macro EXEC_MULDIV_EN.
- Defined: MULLO/DIVU/REMU and the MUL/DIV states are as above.
- Undefined:
  - Those op codes are treated as undefined ops (illegal_op pulse, latency 1).
  - FSM reduces to IDLE only, and in_ready is constant 1.
  - No iteration datapath is synthesized.

Decomposition:
- Package exec_pkg:
  - DATA_W and REG_AW defaults.
  - Op-code localparams: ADD=0, SUB=1, AND=2, OR=3, NOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, MULLO=10, DIVU=11, REMU=12; 13-15 undefined.
  - FSM state encodings: IDLE, MUL, DIV.
- One sub-module, exec_muldiv_seq:
  - Iterative engine with start/op/a/b inputs and done/result outputs, plus its own counter.
  - Instantiated only under EXEC_MULDIV_EN.

Test Plan:
- ADD a=5 b=7 dest=3 wr_en=1 -> next cycle: out_valid=1, result=12, dest_out=3, wr_en_out=1, zero=0.
- SUB a=b=0x1234 back-to-back with OR a=0xF0 b=0x0F -> consecutive pulses: result 0 with zero=1, then 0xFF; in_ready stays 1.
- MULLO a=7 b=6 -> in_ready low for 32 cycles; in_valid pulses meanwhile are ignored; out_valid at cycle 32 with result 42. MULLO 0x00010000*0x00010000 -> result 0.
- DIVU a=100 b=7 -> result 14 at cycle 32. REMU same operands -> 2. DIVU a=9 b=0 -> 0xFFFFFFFF at latency 1.
- rst_n low at cycle 10 of MULLO -> immediate in_ready=1 and out_valid=0; no result pulse afterwards; the next ADD works normally.
- op=15 -> out_valid=1, illegal_op=1, wr_en_out=0, result=0. With EXEC_MULDIV_EN undefined, op=10 gives the same response.
